conv_sched_ctrl: RTL



---
 rtl/conv_sched_ctrl_if.sv | 14 +
 rtl/conv_sched_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/conv_sched_ctrl_if.sv
// Start/done handshake and operand/result bus between the sequencer (master)
// and the convolution controller (slave).
interface conv_sched_ctrl_if;
  logic         start;
  logic [127:0] DATA;
  logic [71:0]  FILTER;
  logic [31:0]  ret;
  logic         done;
  logic         busy;
  logic [2:0]   phase;

  modport master (output start, DATA, FILTER, input ret, done, busy, phase);
  modport slave  (input start, DATA, FILTER, output ret, done, busy, phase);
endinterface

// File: rtl/conv_sched_ctrl.sv
// Sequences a 3x3 convolution of a 4x4 image into a packed 2x2 result using one
// shared multiply-accumulate unit, one tap per cycle over four output positions.
module conv_sched_ctrl #(
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv_sched_ctrl_if.slave bus
);

  // Handshake: start is a request sampled only in IDLE; done pulses for one
  // cycle in DONE and ret is valid from that cycle until the next DONE.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;

  logic [2:0]       state_q, state_d;
  logic [127:0]     data_q, data_d;
  logic [71:0]      filt_q, filt_d;
  logic [1:0]       pos_q, pos_d;
  logic [3:0]       tap_q, tap_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      ret_q, ret_d;

  logic [1:0]       tr, tc, row, col;
  logic [7:0]       d_byte, f_byte, sat_byte;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc_sum, shifted;

  // Tap index decomposed into kernel row/column; image byte index is {row,col}.
  always_comb begin
    tr       = (tap_q >= 4'd6) ? 2'd2 : ((tap_q >= 4'd3) ? 2'd1 : 2'd0);
    tc       = 2'(tap_q - ({2'b00, tr} * 4'd3));
    row      = {1'b0, pos_q[1]} + tr;
    col      = {1'b0, pos_q[0]} + tc;
    d_byte   = data_q[{row, col, 3'b000} +: 8];
    f_byte   = filt_q[{tap_q, 3'b000} +: 8];
    prod     = 16'(d_byte) * 16'(f_byte);
    acc_sum  = (tap_q == 4'd0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    shifted  = acc_sum >> OUT_SHIFT;
    sat_byte = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    filt_d  = filt_q;
    pos_d   = pos_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = bus.DATA;
        filt_d  = bus.FILTER;
        pos_d   = 2'd0;
        tap_d   = 4'd0;
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d = acc_sum;
        if (tap_q == 4'd8) begin
          res_d[{pos_q, 3'b000} +: 8] = sat_byte;
          tap_d = 4'd0;
          pos_d = pos_q + 2'd1;
          if (pos_q == 2'd3) begin
            // ret only ever sees a complete job, including the byte written now.
            ret_d   = res_d;
            state_d = S_DONE;
          end
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      filt_q  <= '0;
      pos_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      filt_q  <= filt_d;
      pos_q   <= pos_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.ret   = ret_q;
  assign bus.done  = (state_q == S_DONE);
  assign bus.busy  = (state_q == S_LOAD) || (state_q == S_CALC);
  assign bus.phase = state_q;

endmodule
